simon_seq_ctrl: RTL
===================

Name: simon_seq_ctrl

Overview:
Parametrised control FSM for the memory-sequence tile game. It replaces the fixed 4-tile, 64-pixel, 3/6/9-length controller. It draws the idle board, then plays back a random sequence of tile flashes. It then checks the player's answers internally and keeps the current and best scores. It sits between the input/random/delay blocks and the tile-drawing datapath; the datapath owns colours and coordinates.

Parameters:
NUM_TILES, 4, number of tiles (2..16)
TILE_BITS, 2, width of a tile index; must satisfy 2**TILE_BITS >= NUM_TILES
TILE_PIXELS, 64, pixels plotted per tile draw
PIX_W, 7, pixel counter width; must satisfy 2**PIX_W > TILE_PIXELS
MAX_LEN, 16, longest sequence supported
LEN_W, 5, length/score counter width; must satisfy 2**LEN_W > MAX_LEN

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; leaves IDLE
level_valid  in  1  1-cycle pulse with level_len; starts a round
level_len  in  LEN_W  requested sequence length
seq  in  MAX_LEN*TILE_BITS  random sequence; step i is seq[i*TILE_BITS +: TILE_BITS]
delay_done  in  1  pulse from the external delay counter
player_valid  in  1  1-cycle pulse: player pressed a tile
player_tile  in  TILE_BITS  tile pressed, qualified by player_valid
rand_req  out  1  1-cycle request to latch a new seq
tile_num  out  TILE_BITS  tile addressed by the datapath
ld_tile  out  1  datapath loads the idle colour/position for tile_num
ld_flash  out  1  datapath loads the flash colour
plot  out  1  write-enable, one pixel per cycle
pixel_idx  out  PIX_W  pixel offset inside the tile
delay_start  out  1  1-cycle pulse that restarts the delay counter
score  out  LEN_W  correct answers in the current round
best_score  out  LEN_W  highest completed score since reset
round_pass  out  1  1-cycle pulse when the player completes the sequence
round_fail  out  1  1-cycle pulse on a wrong tile
busy  out  1  high in every state except IDLE and LEVEL

Behaviour:
- Reset: asynchronous, active-low. State goes to IDLE; every output and every counter is 0.
- Internal registers:
  - len: the clamped level_len. 0 becomes 1; values above MAX_LEN become MAX_LEN.
  - step: current sequence index.
  - pixel_idx.
- DRAW sub-sequence, used by every draw state:
  - pixel_idx is 0 on the first plot cycle.
  - plot is high for exactly TILE_PIXELS consecutive cycles, with pixel_idx running 0..TILE_PIXELS-1.
  - The exit happens in the cycle after pixel_idx reaches TILE_PIXELS-1, with pixel_idx cleared to 0.
- tile_num is registered and stays stable from the load cycle through the end of the draw.
- ld_tile and ld_flash each pulse in the cycle immediately before the first plot of their draw.
- States:
  - IDLE: on start go to BOOT_LOAD with tile=0.
  - BOOT_LOAD (ld_tile) -> BOOT_DRAW. After the draw, if tile < NUM_TILES-1, increment tile and return to BOOT_LOAD; otherwise go to LEVEL.
  - LEVEL: on level_valid, latch len, clear score and step, then go to GEN.
  - GEN: pulse rand_req, then go to SHOW_LOAD. seq must be stable from the next cycle onward.
  - SHOW_LOAD: set tile_num = seq step `step`, pulse ld_tile -> SHOW_FLASH.
  - SHOW_FLASH: pulse ld_flash -> SHOW_DRAW (flash colour).
  - SHOW_DRAW: after the draw, pulse delay_start -> SHOW_HOLD.
  - SHOW_HOLD: on delay_done go to SHOW_RLOAD.
  - SHOW_RLOAD: pulse ld_tile -> SHOW_RDRAW (idle colour).
  - SHOW_RDRAW: after the draw, pulse delay_start -> SHOW_GAP.
  - SHOW_GAP: on delay_done, step+1. If the new step == len, clear step and go to WAIT; otherwise go to SHOW_LOAD.
  - WAIT: on player_valid, compare player_tile with seq step `step`.
    - Match: score+1, then go to ECHO_LOAD with tile_num = player_tile.
    - Mismatch: pulse round_fail and go to LEVEL.
  - ECHO_LOAD -> ECHO_FLASH -> ECHO_DRAW -> ECHO_HOLD -> ECHO_RLOAD -> ECHO_RDRAW -> ECHO_GAP. These behave exactly like the SHOW_ states.
  - ECHO_GAP: on delay_done, step+1. If the new step == len, pulse round_pass, set best_score = max(best_score, score), and go to LEVEL. Otherwise go to WAIT.
- Inputs outside their states are ignored:
  - player_valid outside WAIT; no queueing.
  - level_valid outside LEVEL.
  - start outside IDLE.
- delay_done is ignored outside the HOLD/GAP states.
- A delay_done arriving in the same cycle as delay_start is ignored. Waiting begins in the next cycle.
- step and score never wrap, because len <= MAX_LEN < 2**LEN_W.
- Reset asserted mid-draw or mid-round: everything goes straight to IDLE, and best_score clears.
- Scores are unsigned; best_score updates only on a pass.

Test Plan:
1. Reset, then start -> 4 ld_tile pulses with tile_num 0,1,2,3, each followed by exactly 64 plot cycles with pixel_idx 0..63; then busy=0 in LEVEL.
2. level_len=3, seq steps {2,0,3}, delay_done 5 cycles after each delay_start -> flash/restore pairs on tiles 2,0,3; 6 draws total; ends in WAIT.
3. Player enters 2,0,3 in WAIT -> score 1,2,3; an echo flash per tile; round_pass pulses once; best_score=3.
4. Second round with len=3; player enters 2 then 1 -> round_fail pulses, score=1, best_score stays 3, FSM in LEVEL.
5. level_len=0 -> exactly one step played; level_len=31 with MAX_LEN=16 -> 16 steps played.
6. Assert resetn low mid SHOW_DRAW at pixel_idx=20 -> plot=0 and all outputs 0 immediately; after release, the FSM is in IDLE.

Source files
------------

// File: rtl/simon_seq_ctrl.sv
// simon_seq_ctrl
// Control FSM for the memory-sequence tile game. It draws the idle board and
// plays back a random sequence of tile flashes. It then checks the player's
// answers, echoing each correct press, and keeps the current and best scores.
// Colours and coordinates belong to the datapath. This block only says which
// tile to address, when to load it, and when to plot each pixel.
//
// Ports
//   clock, resetn            clock, asynchronous active-low reset
//   start                    leaves IDLE and draws the idle board
//   level_valid, level_len   starts a round of the requested length
//   seq                      random sequence, TILE_BITS per step
//   delay_done               pulse from the external delay counter
//   player_valid, player_tile  a tile press from the player
//   rand_req                 asks the random block for a new seq
//   tile_num, ld_tile, ld_flash  datapath tile select and load strobes
//   plot, pixel_idx          pixel write enable and pixel offset in the tile
//   delay_start              restarts the delay counter
//   score, best_score        current round score, best completed score
//   round_pass, round_fail   end-of-round pulses
//   busy                     high except in IDLE and LEVEL
module simon_seq_ctrl #(
  parameter int NUM_TILES   = 4,
  parameter int TILE_BITS   = 2,
  parameter int TILE_PIXELS = 64,
  parameter int PIX_W       = 7,
  parameter int MAX_LEN     = 16,
  parameter int LEN_W       = 5
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         start,
  input  logic                         level_valid,
  input  logic [LEN_W-1:0]             level_len,
  input  logic [MAX_LEN*TILE_BITS-1:0] seq,
  input  logic                         delay_done,
  input  logic                         player_valid,
  input  logic [TILE_BITS-1:0]         player_tile,
  output logic                         rand_req,
  output logic [TILE_BITS-1:0]         tile_num,
  output logic                         ld_tile,
  output logic                         ld_flash,
  output logic                         plot,
  output logic [PIX_W-1:0]             pixel_idx,
  output logic                         delay_start,
  output logic [LEN_W-1:0]             score,
  output logic [LEN_W-1:0]             best_score,
  output logic                         round_pass,
  output logic                         round_fail,
  output logic                         busy
);

  typedef enum logic [4:0] {
    IDLE       = 5'd0,  BOOT_LOAD  = 5'd1,  BOOT_DRAW  = 5'd2,  LEVEL      = 5'd3,
    GEN        = 5'd4,  SHOW_LOAD  = 5'd5,  SHOW_FLASH = 5'd6,  SHOW_DRAW  = 5'd7,
    SHOW_HOLD  = 5'd8,  SHOW_RLOAD = 5'd9,  SHOW_RDRAW = 5'd10, SHOW_GAP   = 5'd11,
    WAIT       = 5'd12, ECHO_LOAD  = 5'd13, ECHO_FLASH = 5'd14, ECHO_DRAW  = 5'd15,
    ECHO_HOLD  = 5'd16, ECHO_RLOAD = 5'd17, ECHO_RDRAW = 5'd18, ECHO_GAP   = 5'd19
  } state_t;

  state_t               state_r, state_nxt;
  logic [TILE_BITS-1:0] tile_r, tile_nxt;
  logic [PIX_W-1:0]     pixel_r, pixel_nxt;
  logic [LEN_W-1:0]     step_r, step_nxt;
  logic [LEN_W-1:0]     len_r, len_nxt;
  logic [LEN_W-1:0]     score_r, score_nxt;
  logic [LEN_W-1:0]     best_r, best_nxt;
  logic                 rand_req_r, rand_req_nxt;
  logic                 delay_start_r, delay_start_nxt;
  logic                 pass_r, pass_nxt;
  logic                 fail_r, fail_nxt;
  logic                 ld_tile_r, ld_flash_r, plot_r, busy_r;

  logic                 draw_last_s;
  logic                 delay_ok_s;
  logic [LEN_W-1:0]     step_inc_s;

  function automatic logic is_load(input state_t s);
    case (s)
      BOOT_LOAD, SHOW_LOAD, SHOW_RLOAD, ECHO_LOAD, ECHO_RLOAD: is_load = 1'b1;
      default:                                                is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_flash(input state_t s);
    case (s)
      SHOW_FLASH, ECHO_FLASH: is_flash = 1'b1;
      default:                is_flash = 1'b0;
    endcase
  endfunction

  function automatic logic is_draw(input state_t s);
    case (s)
      BOOT_DRAW, SHOW_DRAW, SHOW_RDRAW, ECHO_DRAW, ECHO_RDRAW: is_draw = 1'b1;
      default:                                                is_draw = 1'b0;
    endcase
  endfunction

  function automatic logic [TILE_BITS-1:0] seq_at(input logic [MAX_LEN*TILE_BITS-1:0] s,
                                                  input logic [LEN_W-1:0] idx);
    seq_at = {TILE_BITS{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx == LEN_W'(i)) seq_at = s[i*TILE_BITS +: TILE_BITS];
    end
  endfunction

  // A zero length still plays one step; anything past MAX_LEN is capped.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == {LEN_W{1'b0}})         clamp_len = LEN_W'(1);
    else if (l > LEN_W'(MAX_LEN))  clamp_len = LEN_W'(MAX_LEN);
    else                           clamp_len = l;
  endfunction

  assign draw_last_s = (pixel_r == PIX_W'(TILE_PIXELS - 1));
  // delay_start is high in the first HOLD/GAP cycle; a delay_done seen then is stale.
  assign delay_ok_s  = delay_done & ~delay_start_r;
  assign step_inc_s  = step_r + LEN_W'(1);

  // Next-state, counter and one-cycle pulse decisions.
  always_comb begin
    state_nxt       = state_r;
    tile_nxt        = tile_r;
    step_nxt        = step_r;
    len_nxt         = len_r;
    score_nxt       = score_r;
    best_nxt        = best_r;
    rand_req_nxt    = 1'b0;
    delay_start_nxt = 1'b0;
    pass_nxt        = 1'b0;
    fail_nxt        = 1'b0;

    if (is_draw(state_r)) begin
      if (draw_last_s) pixel_nxt = {PIX_W{1'b0}};
      else             pixel_nxt = pixel_r + PIX_W'(1);
    end else begin
      pixel_nxt = {PIX_W{1'b0}};
    end

    case (state_r)
      IDLE: begin
        if (start) begin
          tile_nxt  = {TILE_BITS{1'b0}};
          state_nxt = BOOT_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      BOOT_LOAD: state_nxt = BOOT_DRAW;
      BOOT_DRAW: begin
        if (!draw_last_s) begin
          state_nxt = BOOT_DRAW;
        end else if (tile_r < TILE_BITS'(NUM_TILES - 1)) begin
          tile_nxt  = tile_r + TILE_BITS'(1);
          state_nxt = BOOT_LOAD;
        end else begin
          state_nxt = LEVEL;
        end
      end
      LEVEL: begin
        if (level_valid) begin
          len_nxt      = clamp_len(level_len);
          score_nxt    = {LEN_W{1'b0}};
          step_nxt     = {LEN_W{1'b0}};
          rand_req_nxt = 1'b1;
          state_nxt    = GEN;
        end else begin
          state_nxt = LEVEL;
        end
      end
      // GEN spans two cycles: rand_req in the first, and seq is only
      // trusted (and step 0 sampled) in the second.
      GEN: begin
        if (rand_req_r) begin
          state_nxt = GEN;
        end else begin
          tile_nxt  = seq_at(seq, step_r);
          state_nxt = SHOW_LOAD;
        end
      end
      SHOW_LOAD:  state_nxt = SHOW_FLASH;
      SHOW_FLASH: state_nxt = SHOW_DRAW;
      ECHO_LOAD:  state_nxt = ECHO_FLASH;
      ECHO_FLASH: state_nxt = ECHO_DRAW;
      SHOW_RLOAD: state_nxt = SHOW_RDRAW;
      ECHO_RLOAD: state_nxt = ECHO_RDRAW;
      SHOW_DRAW, SHOW_RDRAW, ECHO_DRAW, ECHO_RDRAW: begin
        if (draw_last_s) begin
          delay_start_nxt = 1'b1;
          case (state_r)
            SHOW_DRAW:  state_nxt = SHOW_HOLD;
            SHOW_RDRAW: state_nxt = SHOW_GAP;
            ECHO_DRAW:  state_nxt = ECHO_HOLD;
            default:    state_nxt = ECHO_GAP;
          endcase
        end else begin
          state_nxt = state_r;
        end
      end
      SHOW_HOLD: begin
        if (delay_ok_s) state_nxt = SHOW_RLOAD;
        else            state_nxt = SHOW_HOLD;
      end
      ECHO_HOLD: begin
        if (delay_ok_s) state_nxt = ECHO_RLOAD;
        else            state_nxt = ECHO_HOLD;
      end
      SHOW_GAP: begin
        if (!delay_ok_s) begin
          state_nxt = SHOW_GAP;
        end else if (step_inc_s == len_r) begin
          step_nxt  = {LEN_W{1'b0}};
          state_nxt = WAIT;
        end else begin
          step_nxt  = step_inc_s;
          tile_nxt  = seq_at(seq, step_inc_s);
          state_nxt = SHOW_LOAD;
        end
      end
      WAIT: begin
        if (!player_valid) begin
          state_nxt = WAIT;
        end else if (player_tile == seq_at(seq, step_r)) begin
          score_nxt = score_r + LEN_W'(1);
          tile_nxt  = player_tile;
          state_nxt = ECHO_LOAD;
        end else begin
          fail_nxt  = 1'b1;
          state_nxt = LEVEL;
        end
      end
      ECHO_GAP: begin
        if (!delay_ok_s) begin
          state_nxt = ECHO_GAP;
        end else if (step_inc_s == len_r) begin
          step_nxt  = step_inc_s;
          pass_nxt  = 1'b1;
          if (score_r > best_r) best_nxt = score_r;
          else                  best_nxt = best_r;
          state_nxt = LEVEL;
        end else begin
          step_nxt  = step_inc_s;
          state_nxt = WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and registered outputs; strobes are decoded from the next state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r       <= IDLE;
      tile_r        <= {TILE_BITS{1'b0}};
      pixel_r       <= {PIX_W{1'b0}};
      step_r        <= {LEN_W{1'b0}};
      len_r         <= {LEN_W{1'b0}};
      score_r       <= {LEN_W{1'b0}};
      best_r        <= {LEN_W{1'b0}};
      rand_req_r    <= 1'b0;
      delay_start_r <= 1'b0;
      pass_r        <= 1'b0;
      fail_r        <= 1'b0;
      ld_tile_r     <= 1'b0;
      ld_flash_r    <= 1'b0;
      plot_r        <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      tile_r        <= tile_nxt;
      pixel_r       <= pixel_nxt;
      step_r        <= step_nxt;
      len_r         <= len_nxt;
      score_r       <= score_nxt;
      best_r        <= best_nxt;
      rand_req_r    <= rand_req_nxt;
      delay_start_r <= delay_start_nxt;
      pass_r        <= pass_nxt;
      fail_r        <= fail_nxt;
      ld_tile_r     <= is_load(state_nxt);
      ld_flash_r    <= is_flash(state_nxt);
      plot_r        <= is_draw(state_nxt);
      busy_r        <= (state_nxt != IDLE) && (state_nxt != LEVEL);
    end
  end

  assign rand_req    = rand_req_r;
  assign tile_num    = tile_r;
  assign ld_tile     = ld_tile_r;
  assign ld_flash    = ld_flash_r;
  assign plot        = plot_r;
  assign pixel_idx   = pixel_r;
  assign delay_start = delay_start_r;
  assign score       = score_r;
  assign best_score  = best_r;
  assign round_pass  = pass_r;
  assign round_fail  = fail_r;
  assign busy        = busy_r;

endmodule
